// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              set_err;
  logic              mem_access;
  logic              load_use;

  assign mem_access = mem_rd | mem_wr;
  assign load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State, wait counter, saturating stall counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      mem_err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (set_err)
        mem_err <= 1'b1;
      if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // Next-state and Mealy stage controls; a frozen cycle only kills MEM/WB,
  // branch and load-use decisions are taken on the cycle the pipe moves
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    set_err      = 1'b0;
    dmem_req     = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_flush  = 1'b0;

    case (state)
      RUN: begin
        dmem_req = mem_access;
        if (mem_access && !dmem_ready) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_flush  = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready || (wait_cnt == WAIT_LAST)) begin
          set_err      = !dmem_ready;
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_flush  = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    if (reset) begin
      dmem_req    = 1'b0;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end
  end

endmodule
